ahb_lite_master: RTL

Single-channel AHB-Lite bus initiator. It converts a simple valid/ready command stream into pipelined AHB-Lite SINGLE word transfers, handles slave wait states, and returns one response pulse per transfer. It is the only master on the bus that the address decoder serves, and it drives HADDR into that decoder. Address and data phases overlap, so the sustained throughput is one transfer per cycle when the bus has zero wait states.

---
 rtl/ahb_lite_master.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ahb_lite_master.sv
// Single-channel AHB-Lite initiator: valid/ready commands to pipelined SINGLE word transfers.
// Optional two-cycle ERROR handling with automatic reissue is enabled by AHB_LITE_MASTER_ERR_EN.
module ahb_lite_master (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_ERR1 = 1'b1;

  logic        state;
  logic        retry_pend;
  logic [31:0] wdata_hold;
  logic        dp_valid;
  logic        dp_write;
  logic        accept;
  logic        err_first;
  logic        err_second;
  logic        unused_bits;

  assign HSIZE  = 3'b010;
  assign HBURST = 3'b000;
  assign HPROT  = 4'b0011;

  assign cmd_ready = HREADY && (state == ST_RUN) && !retry_pend;
  assign accept    = cmd_valid && cmd_ready;

  assign unused_bits = ^{HRESP, cmd_addr[1:0]};

`ifdef AHB_LITE_MASTER_ERR_EN
  assign err_first  = (state == ST_RUN) && dp_valid && HRESP && !HREADY;
  assign err_second = (state == ST_ERR1) && HREADY;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= ST_RUN;
      retry_pend <= 1'b0;
    end else if (err_first) begin
      state      <= ST_ERR1;
      retry_pend <= (HTRANS == HTRANS_NONSEQ);
    end else if (err_second) begin
      state      <= ST_RUN;
      retry_pend <= 1'b0;
    end
  end
`else
  assign err_first  = 1'b0;
  assign err_second = 1'b0;
  assign state      = ST_RUN;
  assign retry_pend = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HADDR      <= '0;
      HTRANS     <= HTRANS_IDLE;
      HWRITE     <= 1'b0;
      wdata_hold <= '0;
      HWDATA     <= '0;
      dp_valid   <= 1'b0;
      dp_write   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_write  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (err_first) begin
        // Cancel the stalled address phase; its fields stay for the reissue.
        HTRANS <= HTRANS_IDLE;
      end else if (HREADY) begin
        if (err_second && retry_pend) begin
          HTRANS <= HTRANS_NONSEQ;
        end else if (accept) begin
          HTRANS     <= HTRANS_NONSEQ;
          HADDR      <= {cmd_addr[31:2], 2'b00};
          HWRITE     <= cmd_write;
          wdata_hold <= cmd_wdata;
        end else begin
          HTRANS <= HTRANS_IDLE;
        end

        dp_valid <= (HTRANS == HTRANS_NONSEQ);
        if (HTRANS == HTRANS_NONSEQ) begin
          dp_write <= HWRITE;
          HWDATA   <= wdata_hold;
        end

        if (err_second) begin
          rsp_valid <= 1'b1;
          rsp_write <= dp_write;
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end else if (dp_valid) begin
          rsp_valid <= 1'b1;
          rsp_write <= dp_write;
          rsp_rdata <= dp_write ? '0 : HRDATA;
          rsp_err   <= 1'b0;
        end
      end
    end
  end

endmodule
